// File: rtl/led_arb_pkg.sv
// Shared types and width helpers for the LED bank arbiter and its round-robin picker.
package led_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int owner_w(input int num_req);
      return clog2_min1(num_req);
   endfunction

   function automatic int cnt_w(input int hold_cycles);
      return clog2_min1(hold_cycles);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', with wrap,
// optionally ignoring one index (the current owner during preemption).
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   input  logic         exclude_en,
   input  logic [W-1:0] exclude_idx,
   output logic         any,
   output logic [W-1:0] idx
);

   logic [N-1:0] masked;
   int           slot;

   always_comb begin
      masked = req;
      if (exclude_en) masked[exclude_idx] = 1'b0;
   end

   // Walk offsets from farthest to nearest so the nearest set request is the last write.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      slot = 0;
      for (int k = N; k >= 1; k--) begin
         slot = (int'(last) + k) % N;
         if (masked[slot[W-1:0]]) begin
            any = 1'b1;
            idx = slot[W-1:0];
         end
      end
   end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank with a minimum hold time; the LEDs
// mirror the synchronized slide switches whenever nobody owns the bank.
module led_bank_arbiter
   import led_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int LED_W       = 16,
   parameter int HOLD_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [LED_W-1:0]              sw,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*LED_W-1:0]      req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [LED_W-1:0]              led,
   output logic [owner_w(NUM_REQ)-1:0]   owner,
   output logic                          busy
);

   localparam int OWNER_W = owner_w(NUM_REQ);
   localparam int CNT_W   = cnt_w(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   state_t             state, state_n;
   logic [LED_W-1:0]   sw_meta, sw_s;
   logic [OWNER_W-1:0] last_owner, last_owner_n, owner_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [NUM_REQ-1:0] gnt_n;
   logic [LED_W-1:0]   led_n;
   logic [LED_W-1:0]   data_arr [NUM_REQ];
   logic               en, pick_any;
   logic [OWNER_W-1:0] pick_idx;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[i*LED_W +: LED_W];
   end

   assign en   = sw_s[LED_W-1];
   assign busy = (state == OWN);

   rr_pick #(
      .N (NUM_REQ),
      .W (OWNER_W)
   ) u_pick (
      .req         (req),
      .last        (last_owner),
      .exclude_en  (state == OWN),
      .exclude_idx (owner),
      .any         (pick_any),
      .idx         (pick_idx)
   );

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_owner_n = last_owner;
      cnt_n        = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      gnt_n        = gnt;
      led_n        = sw_s;

      unique case (state)
         IDLE: begin
            cnt_n = cnt;
            if (en && pick_any) begin
               state_n      = OWN;
               owner_n      = pick_idx;
               last_owner_n = pick_idx;
               gnt_n        = NUM_REQ'(1) << pick_idx;
               cnt_n        = '0;
            end
         end
         OWN: begin
            led_n = data_arr[owner];
            if (!en) begin
               state_n = IDLE;
               gnt_n   = '0;
            end else if (!req[owner] || (cnt == CNT_MAX && pick_any)) begin
               // Voluntary release hands over at once; otherwise only after the hold expires.
               if (pick_any) begin
                  owner_n      = pick_idx;
                  last_owner_n = pick_idx;
                  gnt_n        = NUM_REQ'(1) << pick_idx;
                  cnt_n        = '0;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta    <= '0;
         sw_s       <= '0;
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OWNER_W'(NUM_REQ - 1);
         cnt        <= '0;
         gnt        <= '0;
         led        <= '0;
      end else begin
         sw_meta    <= sw;
         sw_s       <= sw_meta;
         state      <= state_n;
         owner      <= owner_n;
         last_owner <= last_owner_n;
         cnt        <= cnt_n;
         gnt        <= gnt_n;
         led        <= led_n;
      end
   end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the board's 16-bit LED bank between NUM_REQ on-chip requesters using round-robin arbitration.
- Each grant is held for a minimum number of cycles.
- When idle or disabled, the LED bank mirrors the synchronized slide switches.
- Sits between the board switch/LED pins and the CPU debug/status producers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LED_W, 16, LED and switch bank width.
- HOLD_CYCLES, 1024, minimum cycles an owner keeps the bank before a pending requester can preempt it (must be >= 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  LED_W  raw slide switches (asynchronous); sw[LED_W-1] is the arbiter enable.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- req_data  in  NUM_REQ*LED_W  requester i pattern in bits [i*LED_W +: LED_W].
- gnt  out  NUM_REQ  one-hot grant, registered.
- led  out  LED_W  LED drive, registered.
- owner  out  $clog2(NUM_REQ)  index of the current owner; valid only while busy.
- busy  out  1  high while in OWN.

Behaviour:
Reset (asynchronous, rst_n=0):
- state=IDLE; gnt=0, led=0, owner=0, busy=0.
- Hold counter 0; last_owner=NUM_REQ-1, so req[0] wins the first arbitration.
- Both synchronizer stages 0.

Switch input:
- sw passes through a 2-flop synchronizer to give sw_s (2-cycle latency).
- en = sw_s[LED_W-1].

Round-robin pick (combinational):
- Search req from (last_owner+1) mod NUM_REQ upward with wrap; the first set bit wins.
- When preempting, exclude the current owner from the search.

FSM states: IDLE, OWN.
- IDLE:
  - led <= sw_s every cycle.
  - If en and |req: next cycle state=OWN, owner=pick, gnt=onehot(pick), counter=0, last_owner=pick.
- OWN:
  - led <= req_data[owner] every cycle, so led shows the owner's data with 1-cycle lag.
  - Counter increments and saturates at HOLD_CYCLES-1.
- Leaving OWN, evaluated in priority order each cycle:
  1. en==0 -> IDLE next cycle, gnt=0. This applies regardless of hold.
  2. req[owner]==0 (voluntary release, allowed before hold expires):
     - If another req is set -> grant it directly, counter=0, no idle cycle.
     - Else -> IDLE.
  3. Counter==HOLD_CYCLES-1 and any other req set -> preempt: switch directly to pick (excluding owner), counter=0.
  4. Otherwise stay in OWN.

Timing and invariants:
- Grant latency: a req rising in IDLE at edge t produces gnt at edge t+1 (1 cycle).
- gnt is always one-hot or zero, never multi-hot.
- gnt changes only on a clock edge.
- busy = (state==OWN).
- owner holds its last value in IDLE.
- Simultaneous requests: round-robin order decides.
- A single persistent requester with no contenders holds the bank indefinitely; the counter stays saturated.
- HOLD_CYCLES=1: preemption is possible every cycle when others request, giving pure round-robin rotation.
- Reset asserted mid-ownership: immediate return to the reset values above; there is no glitch-free requirement on led during reset.
- Counter width: max(1, $clog2(HOLD_CYCLES)).

Decomposition:
- Package led_arb_pkg:
  - state enum {IDLE, OWN}.
  - OWNER_W / CNT_W width functions (clog2 helper).
- Sub-module rr_pick (combinational):
  - inputs: req, last, exclude_en, exclude_idx.
  - outputs: any, idx.
  - reused later by the bus arbiter.
- The 2-flop synchronizer stays inline.

Test Plan (all scenarios with NUM_REQ=4, HOLD_CYCLES=4, LED_W=16):
1. Reset, then sw=16'h8A5A with no req → after 3 clocks led=16'h8A5A, gnt=0, busy=0; pulse rst_n low mid-run → led=0 immediately.
2. en=1, req=4'b0001, req_data[0]=16'h1234 → gnt=4'b0001 one cycle after req, busy=1, led=16'h1234 one cycle after gnt, owner=0.
3. req=4'b1111 held continuously → grants rotate 0→1→2→3→0, each owner held exactly 4 cycles; gnt never multi-hot.
4. Owner 1 drops req after 2 cycles while req[3]=1 → gnt=4'b1000 next cycle (no IDLE cycle, no wait for hold); the drop with no other req → IDLE, led returns to sw_s.
5. Owner 2 active and sw[15] driven 0 → within 3 cycles (sync + 1) gnt=0, busy=0, led=sw_s; set sw[15]=1 with req pending → arbitration resumes starting after last_owner=2, i.e. 3 wins if requesting.
6. Single requester 0 held for 20 cycles, then req[2] rises → owner 0 keeps the bank until the counter saturates, then preemption occurs on the next cycle: gnt=4'b0100.
